// File: rtl/data_memory_arbiter.sv
// Two-master arbiter in front of a single-port data RAM: CPU load/store path and IO DMA.
// One command at a time: IDLE -> ACCESS -> (RESP for loads) -> IDLE.
module data_memory_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int FIXED_PRIORITY = 0,
  parameter int MAX_CPU_RUN    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  io_req,
  input  logic                  io_we,
  input  logic [ADDR_WIDTH-1:0] io_addr,
  input  logic [DATA_WIDTH-1:0] io_wdata,
  output logic                  io_gnt,
  output logic                  io_rvalid,
  output logic [DATA_WIDTH-1:0] io_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int RUN_W = $clog2(MAX_CPU_RUN + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state;
  logic                  cmdIo;
  logic                  cmdWe;
  logic [ADDR_WIDTH-1:0] cmdAddr;
  logic [DATA_WIDTH-1:0] cmdWdata;
  logic                  lastGrantIo;
  logic [RUN_W-1:0]      cpuRun;
  logic                  pickIo;
  logic                  anyReq;
  logic                  inAccess;
  logic                  inResp;
  logic                  cpuDone;

  assign anyReq = cpu_req | io_req;

  // On a tie, fixed priority favours CPU until its run budget is spent;
  // round-robin hands the tie to whoever was not granted last.
  always_comb begin
    pickIo = 1'b0;
    if (io_req && !cpu_req)
      pickIo = 1'b1;
    else if (io_req && cpu_req) begin
      if (FIXED_PRIORITY != 0)
        pickIo = (cpuRun == RUN_W'(MAX_CPU_RUN));
      else
        pickIo = ~lastGrantIo;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmdIo       <= 1'b0;
      cmdWe       <= 1'b0;
      cmdAddr     <= '0;
      cmdWdata    <= '0;
      lastGrantIo <= 1'b1;
      cpuRun      <= '0;
      cpu_rdata   <= '0;
      io_rdata    <= '0;
    end else begin
      case (state)
        IDLE: if (anyReq) begin
          cmdIo       <= pickIo;
          cmdWe       <= pickIo ? io_we    : cpu_we;
          cmdAddr     <= pickIo ? io_addr  : cpu_addr;
          cmdWdata    <= pickIo ? io_wdata : cpu_wdata;
          lastGrantIo <= pickIo;
          state       <= ACCESS;
        end
        ACCESS: begin
          if (!cmdWe) begin
            if (cmdIo) io_rdata  <= mem_rdata;
            else       cpu_rdata <= mem_rdata;
            state <= RESP;
          end else begin
            state <= IDLE;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      // CPU run length only matters while IO is actually waiting.
      if (!io_req)
        cpuRun <= '0;
      else if (state == IDLE && anyReq) begin
        if (pickIo)
          cpuRun <= '0;
        else if (cpuRun != RUN_W'(MAX_CPU_RUN))
          cpuRun <= cpuRun + 1'b1;
      end
    end
  end

  assign inAccess   = (state == ACCESS);
  assign inResp     = (state == RESP);

  assign mem_addr   = inAccess ? cmdAddr  : '0;
  assign mem_wdata  = inAccess ? cmdWdata : '0;
  assign mem_we     = inAccess &  cmdWe;
  assign mem_re     = inAccess & ~cmdWe;

  assign cpu_gnt    = inAccess & ~cmdIo;
  assign io_gnt     = inAccess &  cmdIo;
  assign cpu_rvalid = inResp   & ~cmdIo;
  assign io_rvalid  = inResp   &  cmdIo;

  assign cpuDone    = (cpu_gnt & cmdWe) | cpu_rvalid;
  assign cpu_stall  = cpu_req & ~cpuDone;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench: round-robin instance drives the RAM model; a fixed-priority
// instance (MAX_CPU_RUN=2) shares the same inputs for the priority sequence.
module tb_data_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, io_req, io_we;
  logic [31:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
  logic [31:0] mem_rdata;

  logic        cpuGntR, cpuRvalidR, cpuStallR, ioGntR, ioRvalidR, memWeR, memReR, busyR;
  logic [31:0] cpuRdataR, ioRdataR, memAddrR, memWdataR;
  logic        cpuGntF, cpuRvalidF, cpuStallF, ioGntF, ioRvalidF, memWeF, memReF, busyF;
  logic [31:0] cpuRdataF, ioRdataF, memAddrF, memWdataF;

  logic [31:0] ram [16];
  logic        memOvr;
  logic [31:0] memForce;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign mem_rdata = memOvr ? memForce : ram[memAddrR[5:2]];

  always @(posedge clk)
    if (memWeR) ram[memAddrR[5:2]] <= memWdataR;

  data_memory_arbiter #(.FIXED_PRIORITY(0)) dutR (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpuGntR), .cpu_rvalid(cpuRvalidR), .cpu_rdata(cpuRdataR), .cpu_stall(cpuStallR),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(ioGntR), .io_rvalid(ioRvalidR), .io_rdata(ioRdataR),
    .mem_addr(memAddrR), .mem_wdata(memWdataR), .mem_we(memWeR), .mem_re(memReR),
    .mem_rdata(mem_rdata), .busy(busyR)
  );

  data_memory_arbiter #(.FIXED_PRIORITY(1), .MAX_CPU_RUN(2)) dutF (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpuGntF), .cpu_rvalid(cpuRvalidF), .cpu_rdata(cpuRdataF), .cpu_stall(cpuStallF),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_gnt(ioGntF), .io_rvalid(ioRvalidF), .io_rdata(ioRdataF),
    .mem_addr(memAddrF), .mem_wdata(memWdataF), .mem_we(memWeF), .mem_re(memReF),
    .mem_rdata(mem_rdata), .busy(busyF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    memOvr = 1'b0; memForce = '0;
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    io_req  = 1'b0; io_we  = 1'b0; io_addr  = '0; io_wdata  = '0;

    // Reset state; stall follows cpu_req while reset is held
    tick(); tick();
    chk("rst_busy", busyR, 0);
    chk("rst_gnt", cpuGntR, 0);
    chk("rst_stall", cpuStallR, 1);
    chk("rst_mem_re", memReR, 0);
    cpu_req = 1'b0; reset = 1'b0;

    // CPU store 0x10 <- DEADBEEF
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    #1 chk("st_stall_c1", cpuStallR, 1);
    tick();
    chk("st_gnt", cpuGntR, 1);
    chk("st_mem_we", memWeR, 1);
    chk("st_mem_addr", memAddrR, 32'h10);
    chk("st_mem_wdata", memWdataR, 32'hDEADBEEF);
    chk("st_stall_c2", cpuStallR, 0);

    // CPU load 0x10, request held straight through
    cpu_we = 1'b0;
    tick();
    chk("ld_stall_c1", cpuStallR, 1);
    chk("ld_gnt_idle", cpuGntR, 0);
    tick();
    chk("ld_gnt", cpuGntR, 1);
    chk("ld_mem_re", memReR, 1);
    chk("ld_mem_we", memWeR, 0);
    chk("ld_stall_c2", cpuStallR, 1);
    tick();
    chk("ld_rvalid", cpuRvalidR, 1);
    chk("ld_rdata", cpuRdataR, 32'hDEADBEEF);
    chk("ld_stall_c3", cpuStallR, 0);
    chk("ld_mem_re_resp", memReR, 0);
    cpu_req = 1'b0;
    tick();
    chk("ld_rvalid_off", cpuRvalidR, 0);
    chk("ld_busy_off", busyR, 0);

    // Reset in the ACCESS cycle of an IO store
    io_req = 1'b1; io_we = 1'b1; io_addr = 32'h20; io_wdata = 32'h1234;
    tick();
    chk("rs_io_gnt_pre", ioGntR, 1);
    reset = 1'b1; io_req = 1'b0; cpu_req = 1'b1;
    #1 chk("rs_stall_in_reset", cpuStallR, 1);
    tick();
    chk("rs_mem_we", memWeR, 0);
    chk("rs_io_gnt", ioGntR, 0);
    chk("rs_busy", busyR, 0);
    chk("rs_cpu_rdata", cpuRdataR, 0);
    chk("rs_io_rdata", ioRdataR, 0);
    tick();
    chk("rs_busy2", busyR, 0);
    chk("rs_cpu_gnt", cpuGntR, 0);
    reset = 1'b0; cpu_req = 1'b0;

    // Round-robin tie: CPU, IO, CPU, IO
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h1;
    io_req  = 1'b1; io_we  = 1'b1; io_addr  = 32'h4; io_wdata  = 32'h2;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rr_gnt%0d", i), {cpuGntR, ioGntR}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    cpu_req = 1'b0; io_req = 1'b0;
    tick();

    // Fixed priority, MAX_CPU_RUN=2: CPU, CPU, IO repeating
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cpu_req = 1'b1; io_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("fp_gnt%0d", i), {cpuGntF, ioGntF}, (i % 3 == 2) ? 2'b01 : 2'b10);
      chk($sformatf("fp_rr_gnt%0d", i), {cpuGntR, ioGntR}, (i % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    cpu_req = 1'b0; io_req = 1'b0;
    tick();

    // IO pulse while CPU store is executing is never granted
    cpu_req = 1'b1; cpu_we = 1'b1;
    tick();
    chk("wd1_cpu_gnt", cpuGntR, 1);
    cpu_req = 1'b0; io_req = 1'b1;
    tick();
    io_req = 1'b0;
    #1 chk("wd1_busy_a", busyR, 0);
    tick();
    chk("wd1_io_gnt", ioGntR, 0);
    chk("wd1_busy_b", busyR, 0);

    // IO pulse in IDLE is latched and completes with the original command
    io_req = 1'b1; io_we = 1'b1; io_addr = 32'h30; io_wdata = 32'hCAFE0001;
    tick();
    io_req = 1'b0; io_addr = 32'h99; io_wdata = 32'h0;
    #1;
    chk("wd2_io_gnt", ioGntR, 1);
    chk("wd2_mem_addr", memAddrR, 32'h30);
    chk("wd2_mem_wdata", memWdataR, 32'hCAFE0001);
    chk("wd2_mem_we", memWeR, 1);
    tick();
    chk("wd2_busy_off", busyR, 0);

    // IO load of the word just written
    io_req = 1'b1; io_we = 1'b0; io_addr = 32'h30;
    tick();
    io_req = 1'b0;
    chk("io_ld_gnt", ioGntR, 1);
    tick();
    chk("io_ld_rvalid", ioRvalidR, 1);
    chk("io_ld_rdata", ioRdataR, 32'hCAFE0001);
    chk("io_ld_cpu_rvalid", cpuRvalidR, 0);
    tick();

    // RAM data changes in RESP; response keeps the ACCESS-cycle sample
    memOvr = 1'b1; memForce = 32'h0000_00A5;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
    tick();
    cpu_req = 1'b0;
    chk("dist_mem_re", memReR, 1);
    tick();
    memForce = 32'h0000_005A;
    #1;
    chk("dist_rvalid", cpuRvalidR, 1);
    chk("dist_rdata", cpuRdataR, 32'h0000_00A5);
    tick();
    chk("dist_rdata_held", cpuRdataR, 32'h0000_00A5);
    chk("dist_rvalid_off", cpuRvalidR, 0);
    memOvr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
